// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: region codes, MMIO offsets,
// STATUS bit layout and the STATUS word packing helper.
package dmem_pkg;

    localparam logic [3:0] REGION_RAM  = 4'h0;
    localparam logic [3:0] REGION_MMIO = 4'h1;

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RX_DATA = 8'h04;
    localparam logic [7:0] OFF_RX_POP  = 8'h08;
    localparam logic [7:0] OFF_TX_DATA = 8'h0C;
    localparam logic [7:0] OFF_ERR_CLR = 8'h10;
    localparam logic [7:0] OFF_CYCLES  = 8'h14;

    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_TX_FULL     = 1;
    localparam int unsigned ST_RX_FULL     = 2;
    localparam int unsigned ST_TX_EMPTY    = 3;
    localparam int unsigned ST_RX_CNT_LSB  = 4;
    localparam int unsigned ST_TX_CNT_LSB  = 8;
    localparam int unsigned ST_ERR_BIT     = 16;

    // Pack FIFO flags, counts and the sticky error into the STATUS register image.
    function automatic logic [31:0] build_status(
        input logic       rx_nonempty,
        input logic       tx_full,
        input logic       rx_full,
        input logic       tx_empty,
        input logic [3:0] rx_cnt,
        input logic [3:0] tx_cnt,
        input logic       err
    );
        logic [31:0] s;
        s = '0;
        s[ST_RX_NONEMPTY]              = rx_nonempty;
        s[ST_TX_FULL]                  = tx_full;
        s[ST_RX_FULL]                  = rx_full;
        s[ST_TX_EMPTY]                 = tx_empty;
        s[ST_RX_CNT_LSB +: 4]          = rx_cnt;
        s[ST_TX_CNT_LSB +: 4]          = tx_cnt;
        s[ST_ERR_BIT]                  = err;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; head is forced to zero while empty.
// Push is ignored when full and pop is ignored when empty (flags sampled before the edge).
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             i_rst,
    input  logic                             i_push,
    input  logic                             i_pop,
    input  logic [WIDTH-1:0]                 i_data,
    output logic [WIDTH-1:0]                 o_head,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [$clog2(DEPTH+1)-1:0]       o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data memory: word RAM plus an MMIO window bridging firmware to host RX/TX FIFOs.
// Optional free-running cycle counter at offset 0x14 when DMEM_CYCLE_COUNTER_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready
);

    localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
    localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]        r_ram [RAM_WORDS];
    logic               r_err;

    logic [3:0]         w_region;
    logic [7:0]         w_off;
    logic [RAM_AW-1:0]  w_ram_idx;
    logic               w_ram_sel;
    logic               w_mmio_sel;
    logic               w_mmio_wr;
    logic               w_rx_pop_req;
    logic               w_tx_push_req;
    logic               w_err_clr;
    logic               w_err_set;

    logic [31:0]        w_rx_head;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic [FIFO_CW-1:0] w_rx_count;
    logic [31:0]        w_tx_head;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic [FIFO_CW-1:0] w_tx_count;

    logic [31:0]        w_status;
    logic [31:0]        w_cycles;
    logic               w_unused;

    assign w_region   = ALUOutM[31:28];
    assign w_off      = ALUOutM[7:0];
    assign w_ram_idx  = ALUOutM[RAM_AW+1:2];
    assign w_ram_sel  = (w_region == REGION_RAM);
    assign w_mmio_sel = (w_region == REGION_MMIO);
    assign w_unused   = ^{ALUOutM[27:RAM_AW+2], ALUOutM[1:0]};

    assign w_mmio_wr     = MemWriteM & w_mmio_sel;
    assign w_rx_pop_req  = w_mmio_wr & (w_off == OFF_RX_POP);
    assign w_tx_push_req = w_mmio_wr & (w_off == OFF_TX_DATA);
    assign w_err_clr     = w_mmio_wr & (w_off == OFF_ERR_CLR);
    assign w_err_set     = (w_rx_pop_req & w_rx_empty) | (w_tx_push_req & w_tx_full);

    always_ff @(posedge clk) begin
        if (MemWriteM && w_ram_sel) begin
            r_ram[w_ram_idx] <= WriteDataM;
        end
    end

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .i_rst   (reset),
        .i_push  (rx_valid),
        .i_pop   (w_rx_pop_req),
        .i_data  (rx_data),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .i_rst   (reset),
        .i_push  (w_tx_push_req),
        .i_pop   (tx_ready),
        .i_data  (WriteDataM),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    assign rx_ready = ~w_rx_full;
    assign tx_valid = ~w_tx_empty;
    assign tx_data  = w_tx_head;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    assign w_status = build_status(~w_rx_empty, w_tx_full, w_rx_full, w_tx_empty,
                                   4'(w_rx_count), 4'(w_tx_count), r_err);

    // Same-cycle load path; unmapped regions and offsets read zero.
    always_comb begin
        ReadData = '0;
        if (w_ram_sel) begin
            ReadData = r_ram[w_ram_idx];
        end else if (w_mmio_sel) begin
            case (w_off)
                OFF_STATUS:  ReadData = w_status;
                OFF_RX_DATA: ReadData = w_rx_head;
                OFF_CYCLES:  ReadData = w_cycles;
                default:     ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (RAM, RX/TX FIFOs, errors, reset, cycles).
// Honors DMEM_CYCLE_COUNTER_EN to pick the expected CYCLES behaviour.
module tb_dmem_responder;

    localparam logic [31:0] A_STATUS  = 32'h1000_0000;
    localparam logic [31:0] A_RX_DATA = 32'h1000_0004;
    localparam logic [31:0] A_RX_POP  = 32'h1000_0008;
    localparam logic [31:0] A_TX_DATA = 32'h1000_000C;
    localparam logic [31:0] A_ERR_CLR = 32'h1000_0010;
    localparam logic [31:0] A_CYCLES  = 32'h1000_0014;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadData;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadData   (ReadData),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWriteM  = 1'b1;
        ALUOutM    = a;
        WriteDataM = d;
        @(negedge clk);
        MemWriteM  = 1'b0;
    endtask

    task automatic cpu_rd(input logic [31:0] a, output logic [31:0] d);
        MemWriteM = 1'b0;
        ALUOutM   = a;
        #1;
        d = ReadData;
    endtask

    task automatic host_push(input logic [31:0] d);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        n_tests++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: rx_ready=%b tx_valid=%b tx_data=%h, want 1 0 0", rx_ready, tx_valid, tx_data);
        end
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (v !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL reset_status: got %h want 00000008", v);
        end
    endtask

    task automatic test_ram;
        logic [31:0] v;
        cpu_wr(32'h0000_0010, 32'hDEAD_BEEF);
        cpu_rd(32'h0000_0010, v);
        n_tests++;
        if (v !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL ram_load: got %h want deadbeef", v);
        end
        cpu_rd(32'h0000_0410, v);
        n_tests++;
        if (v !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL ram_wrap: got %h want deadbeef", v);
        end
        cpu_wr(32'h0000_0014, 32'h1234_5678);
        cpu_rd(32'h0000_0017, v);
        n_tests++;
        if (v !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL ram_word2: got %h want 12345678", v);
        end
        cpu_wr(32'h2000_0010, 32'hFFFF_FFFF);
        cpu_rd(32'h2000_0010, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read: got %h want 0", v);
        end
        cpu_rd(32'h0000_0010, v);
        n_tests++;
        if (v !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL unmapped_write_ignored: got %h want deadbeef", v);
        end
    endtask

    task automatic test_rx;
        logic [31:0] v;
        host_push(32'h11);
        host_push(32'h22);
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (v[7:4] !== 4'd2 || v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_status: got %h want cnt 2 nonempty", v);
        end
        cpu_rd(A_RX_DATA, v);
        n_tests++;
        if (v !== 32'h11) begin
            n_fail++;
            $display("FAIL rx_head0: got %h want 11", v);
        end
        cpu_rd(A_RX_DATA, v);
        n_tests++;
        if (v !== 32'h11) begin
            n_fail++;
            $display("FAIL rx_read_no_side_effect: got %h want 11", v);
        end
        cpu_wr(A_RX_POP, 32'h0);
        cpu_rd(A_RX_DATA, v);
        n_tests++;
        if (v !== 32'h22) begin
            n_fail++;
            $display("FAIL rx_head1: got %h want 22", v);
        end
        cpu_wr(A_RX_POP, 32'h0);
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (v !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL rx_drained_status: got %h want 00000008", v);
        end
    endtask

    task automatic test_rx_overflow;
        logic [31:0] v;
        for (int i = 0; i < 8; i++) host_push(32'h100 + 32'(i));
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (rx_ready !== 1'b0 || v[2] !== 1'b1 || v[7:4] !== 4'd8) begin
            n_fail++;
            $display("FAIL rx_full: rx_ready=%b status=%h want 0, full, cnt 8", rx_ready, v);
        end
        // Host offers a 9th word while the CPU pops in the same cycle.
        @(negedge clk);
        rx_valid   = 1'b1;
        rx_data    = 32'h99;
        MemWriteM  = 1'b1;
        ALUOutM    = A_RX_POP;
        #1;
        n_tests++;
        if (rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_full_pop_ready: got %b want 0", rx_ready);
        end
        @(negedge clk);
        rx_valid  = 1'b0;
        MemWriteM = 1'b0;
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (rx_ready !== 1'b1 || v[7:4] !== 4'd7) begin
            n_fail++;
            $display("FAIL rx_after_pop: rx_ready=%b cnt=%0d want 1, 7", rx_ready, v[7:4]);
        end
        for (int i = 1; i < 8; i++) begin
            cpu_rd(A_RX_DATA, v);
            n_tests++;
            if (v !== 32'h100 + 32'(i)) begin
                n_fail++;
                $display("FAIL rx_order[%0d]: got %h want %h", i, v, 32'h100 + 32'(i));
            end
            cpu_wr(A_RX_POP, 32'h0);
        end
        cpu_rd(A_RX_DATA, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL rx_empty_data: got %h want 0", v);
        end
    endtask

    task automatic test_tx_backpressure;
        logic [31:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) cpu_wr(A_TX_DATA, 32'hA0 + 32'(i));
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (v[16] !== 1'b1 || v[11:8] !== 4'd8 || v[1] !== 1'b1 || v[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_overflow_status: got %h want err, cnt 8, full", v);
        end
        cpu_wr(A_ERR_CLR, 32'h0);
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (v[16] !== 1'b0 || v[11:8] !== 4'd8) begin
            n_fail++;
            $display("FAIL err_clr: got %h want err 0 cnt 8", v);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 32'hA0 + 32'(i)) begin
                n_fail++;
                $display("FAIL tx_drain[%0d]: valid=%b data=%h want 1 %h", i, tx_valid, tx_data, 32'hA0 + 32'(i));
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL tx_drained: valid=%b data=%h want 0 0", tx_valid, tx_data);
        end
    endtask

    task automatic test_boundaries;
        logic [31:0] v;
        cpu_wr(A_RX_POP, 32'h0);
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (v[16] !== 1'b1 || v[7:4] !== 4'd0) begin
            n_fail++;
            $display("FAIL pop_empty: got %h want err 1 cnt 0", v);
        end
        cpu_wr(A_ERR_CLR, 32'h0);
        cpu_wr(A_TX_DATA, 32'h55);
        // CPU push and host pop in the same cycle with one TX entry held.
        @(negedge clk);
        tx_ready   = 1'b1;
        MemWriteM  = 1'b1;
        ALUOutM    = A_TX_DATA;
        WriteDataM = 32'h66;
        #1;
        n_tests++;
        if (tx_data !== 32'h55) begin
            n_fail++;
            $display("FAIL tx_pushpop_head: got %h want 55", tx_data);
        end
        @(negedge clk);
        tx_ready  = 1'b0;
        MemWriteM = 1'b0;
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (v[11:8] !== 4'd1 || tx_data !== 32'h66 || v[16] !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_pushpop: status=%h tx_data=%h want cnt 1 data 66 err 0", v, tx_data);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        host_push(32'h77);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 32'h88;
        tx_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: rx_ready=%b tx_valid=%b tx_data=%h want 1 0 0", rx_ready, tx_valid, tx_data);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cpu_rd(A_STATUS, v);
        n_tests++;
        if (v !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL reset_mid_status: got %h want 00000008", v);
        end
        cpu_rd(32'h0000_0010, v);
        n_tests++;
        if (v !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL ram_kept_over_reset: got %h want deadbeef", v);
        end
    endtask

    task automatic test_cycles;
        logic [31:0] a;
        logic [31:0] b;
        cpu_rd(A_CYCLES, a);
        repeat (10) @(negedge clk);
        cpu_rd(A_CYCLES, b);
`ifdef DMEM_CYCLE_COUNTER_EN
        n_tests++;
        if (b - a !== 32'd10) begin
            n_fail++;
            $display("FAIL cycles_delta: got %0d want 10", b - a);
        end
`else
        n_tests++;
        if (a !== 32'h0 || b !== 32'h0) begin
            n_fail++;
            $display("FAIL cycles_disabled: got %h %h want 0 0", a, b);
        end
`endif
    endtask

    initial begin
        reset      = 1'b1;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'h0;
        WriteDataM = 32'h0;
        rx_valid   = 1'b0;
        rx_data    = 32'h0;
        tx_ready   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_ram();
        test_rx();
        test_rx_overflow();
        test_tx_backpressure();
        test_boundaries();
        test_reset_mid();
        test_cycles();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
